// File: rtl/dot_mac_pkg.sv
// Shared sideband type, pipeline constants and extend/saturate helpers for the dot-product MAC.
package dot_mac_pkg;
  localparam int PIPE_DEPTH = 4;
  localparam int BEAT_CNT_W = 16;
  localparam int MAX_W      = 64;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } stage_sb_t;

  function automatic logic [MAX_W-1:0] lo_mask(input int w);
    return (w >= MAX_W) ? {MAX_W{1'b1}} : ((MAX_W'(1) << w) - MAX_W'(1));
  endfunction

  // Widen a w-bit value held in the low bits of v to the full container.
  function automatic logic [MAX_W-1:0] ext_to(input logic [MAX_W-1:0] v, input int w,
                                              input logic sgn);
    logic [MAX_W-1:0] m;
    logic             top;
    m   = lo_mask(w);
    top = |(v & (MAX_W'(1) << (w - 1)));
    return (sgn && top) ? (v | ~m) : (v & m);
  endfunction

  // w-bit add that clamps to the representable range; ovf flags a clamp.
  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a, b, input int w,
                                               input logic sgn, output logic ovf);
    logic [MAX_W-1:0] m, hb, r;
    logic [MAX_W:0]   s;
    logic             a_neg, b_neg, r_neg;
    m     = lo_mask(w);
    hb    = MAX_W'(1) << (w - 1);
    s     = {1'b0, a & m} + {1'b0, b & m};
    r     = s[MAX_W-1:0] & m;
    a_neg = |(a & hb);
    b_neg = |(b & hb);
    r_neg = |(r & hb);
    if (sgn) begin
      ovf = (a_neg == b_neg) && (r_neg != a_neg);
      if (ovf) r = a_neg ? hb : (m >> 1);
    end else begin
      ovf = s[MAX_W] || (|(s[MAX_W-1:0] & ~m));
      if (ovf) r = m;
    end
    return r;
  endfunction
endpackage

// File: rtl/dot_mac_lane.sv
// One registered lane multiplier, sign- or zero-extending its operands per SIGNED.
module dot_mac_lane #(
  parameter int DATA_WIDTH = 16,
  parameter int SIGNED     = 1
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    en,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [2*DATA_WIDTH-1:0] p
);
  logic sa, sb;
  (* use_dsp = "yes" *) logic [2*DATA_WIDTH-1:0] p_q;

  assign sa = (SIGNED != 0) && a[DATA_WIDTH-1];
  assign sb = (SIGNED != 0) && b[DATA_WIDTH-1];
  assign p  = p_q;

  // Truncated 2W-bit product of the extended operands is exact in both modes.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) p_q <= '0;
    else if (en) p_q <= {{DATA_WIDTH{sa}}, a} * {{DATA_WIDTH{sb}}, b};
  end
endmodule

// File: rtl/pipelined_dot_mac.sv
// LANES-wide dot product accumulated over first/last framed beats, bias added once per frame.
// Optional DOT_MAC_SATURATE_EN: saturating accumulate plus out_sat flag.
module pipelined_dot_mac
  import dot_mac_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 48,
  parameter int SIGNED     = 1
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_a,
  input  logic [LANES*DATA_WIDTH-1:0] in_b,
  input  logic [ACC_WIDTH-1:0]        in_bias,
  input  logic                        in_first,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_WIDTH-1:0]        out_result,
  output logic [BEAT_CNT_W-1:0]       out_beats,
  output logic                        ap_idle
`ifdef DOT_MAC_SATURATE_EN
  ,
  output logic                        out_sat
`endif
);
  localparam int   PROD_W = 2 * DATA_WIDTH;
  localparam logic SGN    = (SIGNED != 0);

  logic                        en;
  stage_sb_t                   s0_sb, s1_sb;
  logic [LANES*DATA_WIDTH-1:0] s0_a, s0_b;
  logic [ACC_WIDTH-1:0]        s0_bias, s1_bias;
  logic [PROD_W-1:0]           s1_prod [LANES];
  logic [ACC_WIDTH-1:0]        s2_sum;
  logic                        s3_valid, s3_last, frame_open, start;
  logic [ACC_WIDTH-1:0]        acc, acc_next;
  logic [BEAT_CNT_W-1:0]       beats;
  logic [PIPE_DEPTH-2:0]       stage_valid;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s0_sb <= '0;
    end else if (en) begin
      s0_sb   <= '{valid: in_valid, first: in_first, last: in_last};
      s0_a    <= in_a;
      s0_b    <= in_b;
      s0_bias <= in_bias;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dot_mac_lane #(.DATA_WIDTH(DATA_WIDTH), .SIGNED(SIGNED)) u_lane (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .en     (en),
      .a      (s0_a[i*DATA_WIDTH +: DATA_WIDTH]),
      .b      (s0_b[i*DATA_WIDTH +: DATA_WIDTH]),
      .p      (s1_prod[i])
    );
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_sb <= '0;
    end else if (en) begin
      s1_sb   <= s0_sb;
      s1_bias <= s0_bias;
    end
  end

  always_comb begin
    s2_sum = '0;
    for (int i = 0; i < LANES; i++)
      s2_sum = s2_sum + ACC_WIDTH'(ext_to(MAX_W'(s1_prod[i]), PROD_W, SGN));
  end

  // A first beat, or any beat with no frame open, restarts the sum from the bias.
  assign start = s1_sb.first || !frame_open;

`ifdef DOT_MAC_SATURATE_EN
  logic beat_sat, frame_sat;
  always_comb begin
    beat_sat = 1'b0;
    if (start)
      acc_next = ACC_WIDTH'(sat_add(MAX_W'(s2_sum), MAX_W'(s1_bias), ACC_WIDTH, SGN, beat_sat));
    else
      acc_next = ACC_WIDTH'(sat_add(MAX_W'(acc), MAX_W'(s2_sum), ACC_WIDTH, SGN, beat_sat));
  end
`else
  always_comb acc_next = start ? (s2_sum + s1_bias) : (acc + s2_sum);
`endif

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s3_valid   <= 1'b0;
      s3_last    <= 1'b0;
      frame_open <= 1'b0;
      acc        <= '0;
      beats      <= '0;
`ifdef DOT_MAC_SATURATE_EN
      frame_sat  <= 1'b0;
`endif
    end else if (en) begin
      s3_valid <= s1_sb.valid;
      s3_last  <= s1_sb.last;
      if (s1_sb.valid) begin
        acc        <= acc_next;
        beats      <= start ? BEAT_CNT_W'(1) : ((&beats) ? beats : beats + BEAT_CNT_W'(1));
        frame_open <= !s1_sb.last;
`ifdef DOT_MAC_SATURATE_EN
        frame_sat  <= start ? beat_sat : (frame_sat || beat_sat);
`endif
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_beats  <= '0;
`ifdef DOT_MAC_SATURATE_EN
      out_sat    <= 1'b0;
`endif
    end else if (en) begin
      out_valid <= s3_valid && s3_last;
      if (s3_valid && s3_last) begin
        out_result <= acc;
        out_beats  <= beats;
`ifdef DOT_MAC_SATURATE_EN
        out_sat    <= frame_sat;
`endif
      end
    end
  end

  assign stage_valid = {s3_valid, s1_sb.valid, s0_sb.valid};
  assign ap_idle     = !(|stage_valid) && !frame_open && !out_valid;
endmodule

// File: tb/tb_pipelined_dot_mac.sv
// Directed self-checking bench for pipelined_dot_mac (48-bit default and a 33-bit instance).
module tb_pipelined_dot_mac;
  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [63:0] in_a = '0, in_b = '0;
  logic [47:0] in_bias = '0;
  logic        in_ready, out_valid, ap_idle;
  logic [47:0] out_result;
  logic [15:0] out_beats;
  logic        in_ready33, out_valid33, ap_idle33;
  logic [32:0] out_result33;
  logic [15:0] out_beats33;
`ifdef DOT_MAC_SATURATE_EN
  logic        out_sat, out_sat33;
  logic        q_sat[$], q33_sat[$];
`endif
  logic [47:0] q_res[$];
  logic [15:0] q_beats[$];
  logic [32:0] q33_res[$];
  int checks = 0, failures = 0;

  localparam logic [63:0] ALL1  = {4{16'd1}};
  localparam logic [63:0] ALL2  = {4{16'd2}};
  localparam logic [63:0] ALL3  = {4{16'd3}};
  localparam logic [63:0] A1234 = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [63:0] B5678 = {16'd8, 16'd7, 16'd6, 16'd5};

  always #5 ap_clk = ~ap_clk;

  pipelined_dot_mac #(.DATA_WIDTH(16), .LANES(4), .ACC_WIDTH(48), .SIGNED(1)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_bias(in_bias), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_beats(out_beats), .ap_idle(ap_idle)
`ifdef DOT_MAC_SATURATE_EN
    , .out_sat(out_sat)
`endif
  );

  pipelined_dot_mac #(.DATA_WIDTH(16), .LANES(4), .ACC_WIDTH(33), .SIGNED(1)) dut33 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready33),
    .in_a(in_a), .in_b(in_b), .in_bias(in_bias[32:0]), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid33), .out_ready(out_ready), .out_result(out_result33),
    .out_beats(out_beats33), .ap_idle(ap_idle33)
`ifdef DOT_MAC_SATURATE_EN
    , .out_sat(out_sat33)
`endif
  );

  always @(posedge ap_clk) begin
    if (out_valid && out_ready) begin
      q_res.push_back(out_result);
      q_beats.push_back(out_beats);
`ifdef DOT_MAC_SATURATE_EN
      q_sat.push_back(out_sat);
`endif
    end
    if (out_valid33 && out_ready) begin
      q33_res.push_back(out_result33);
`ifdef DOT_MAC_SATURATE_EN
      q33_sat.push_back(out_sat33);
`endif
    end
  end

  task automatic clear_q();
    q_res.delete(); q_beats.delete(); q33_res.delete();
`ifdef DOT_MAC_SATURATE_EN
    q_sat.delete(); q33_sat.delete();
`endif
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [47:0] bias,
                      input logic first, input logic last);
    int n = 0;
    in_a = a; in_b = b; in_bias = bias; in_first = first; in_last = last; in_valid = 1'b1;
    while (!(in_ready && in_ready33) && n < 200) begin @(posedge ap_clk); #1; n++; end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int k = 0;
    while ((q_res.size() < n || q33_res.size() < n) && k < 300) begin @(posedge ap_clk); #1; k++; end
    if (k >= 300) begin
      checks++; failures++;
      $display("FAIL result_timeout got=%0d required=%0d", q_res.size(), n);
    end
    repeat (5) @(posedge ap_clk);
    #1;
    checks++;
    if (q_res.size() != n) begin
      failures++; $display("FAIL result_count got=%0d required=%0d", q_res.size(), n);
    end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1; ap_rst = 1'b0;
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b required=0", out_valid); end
    if (out_result !== 48'd0) begin failures++; $display("FAIL rst_out_result got=%0h required=0", out_result); end
    if (out_beats !== 16'd0) begin failures++; $display("FAIL rst_out_beats got=%0h required=0", out_beats); end
    if (ap_idle !== 1'b1) begin failures++; $display("FAIL rst_ap_idle got=%0b required=1", ap_idle); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0b required=1", in_ready); end
  endtask

  task automatic test_single_beat();
    clear_q();
    send(A1234, B5678, 48'd10, 1'b1, 1'b1);
    repeat (2) @(posedge ap_clk);
    #1; checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_early got=%0b required=0", out_valid); end
    @(posedge ap_clk); #1;
    checks += 3;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL latency_4 got=%0b required=1", out_valid); end
    if (out_result !== 48'd80) begin failures++; $display("FAIL single_result got=%0d required=80", out_result); end
    if (out_beats !== 16'd1) begin failures++; $display("FAIL single_beats got=%0d required=1", out_beats); end
    wait_results(1);
  endtask

  task automatic test_back_to_back();
    clear_q(); out_ready = 1'b1;
    send(ALL1, ALL2, 48'd100, 1'b1, 1'b0);
    send(ALL1, ALL2, 48'd999, 1'b0, 1'b0);
    send(ALL1, ALL2, 48'd999, 1'b0, 1'b1);
    send(A1234, B5678, 48'd10, 1'b1, 1'b1);
    send(ALL2, ALL3, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b0);
    send(ALL2, ALL3, 48'd0, 1'b0, 1'b1);
    wait_results(3);
    checks += 6;
    if (q_res[0] !== 48'd124) begin failures++; $display("FAIL b2b_res0 got=%0d required=124", q_res[0]); end
    if (q_beats[0] !== 16'd3) begin failures++; $display("FAIL b2b_beats0 got=%0d required=3", q_beats[0]); end
    if (q_res[1] !== 48'd80) begin failures++; $display("FAIL b2b_res1 got=%0d required=80", q_res[1]); end
    if (q_beats[1] !== 16'd1) begin failures++; $display("FAIL b2b_beats1 got=%0d required=1", q_beats[1]); end
    if (q_res[2] !== 48'd47) begin failures++; $display("FAIL b2b_res2 got=%0d required=47", q_res[2]); end
    if (q_beats[2] !== 16'd2) begin failures++; $display("FAIL b2b_beats2 got=%0d required=2", q_beats[2]); end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    clear_q(); out_ready = 1'b0;
    send(A1234, B5678, 48'd0, 1'b1, 1'b1);
    repeat (5) @(posedge ap_clk);
    #1; checks += 3;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%0b required=0", in_ready); end
    if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid got=%0b required=1", out_valid); end
    if (out_result !== 48'd70) begin failures++; $display("FAIL bp_result got=%0d required=70", out_result); end
    fork
      begin
        send(ALL3, ALL3, 48'd5, 1'b1, 1'b0);
        send(ALL3, ALL3, 48'd999, 1'b0, 1'b1);
        send({4{16'hFFFF}}, ALL1, 48'd0, 1'b1, 1'b1);
      end
      begin
        repeat (10) begin
          @(posedge ap_clk); #1;
          if (!(out_valid === 1'b1 && out_result === 48'd70 && in_ready === 1'b0)) bad++;
        end
        out_ready = 1'b1;
      end
    join
    checks++;
    if (bad != 0) begin failures++; $display("FAIL bp_hold_stable got=%0d bad_cycles required=0", bad); end
    wait_results(3);
    checks += 5;
    if (q_res[0] !== 48'd70) begin failures++; $display("FAIL bp_res0 got=%0d required=70", q_res[0]); end
    if (q_res[1] !== 48'd77) begin failures++; $display("FAIL bp_res1 got=%0d required=77", q_res[1]); end
    if (q_beats[1] !== 16'd2) begin failures++; $display("FAIL bp_beats1 got=%0d required=2", q_beats[1]); end
    if (q_res[2] !== 48'hFFFF_FFFF_FFFC) begin failures++; $display("FAIL bp_res2 got=%0h required=fffffffffffc", q_res[2]); end
    if (q_beats[2] !== 16'd1) begin failures++; $display("FAIL bp_beats2 got=%0d required=1", q_beats[2]); end
  endtask

  task automatic test_signed();
    clear_q();
    send({4{16'hFFFD}}, {4{16'd4}}, 48'd0, 1'b1, 1'b1);
    wait_results(1);
    checks++;
    if (q_res[0] !== 48'hFFFF_FFFF_FFD0) begin failures++; $display("FAIL signed_res got=%0h required=ffffffffffd0", q_res[0]); end
  endtask

  task automatic test_reset_mid_frame();
    clear_q();
    send(ALL1, ALL1, 48'd0, 1'b1, 1'b0);
    send(ALL1, ALL1, 48'd0, 1'b0, 1'b0);
    repeat (4) @(posedge ap_clk);
    #1; checks++;
    if (ap_idle !== 1'b0) begin failures++; $display("FAIL open_frame_idle got=%0b required=0", ap_idle); end
    ap_rst = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1; ap_rst = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1; checks += 2;
    if (ap_idle !== 1'b1) begin failures++; $display("FAIL gap_idle got=%0b required=1", ap_idle); end
    if (q_res.size() != 0) begin failures++; $display("FAIL gap_no_result got=%0d required=0", q_res.size()); end
    send(ALL1, ALL1, 48'd7, 1'b0, 1'b1);
    wait_results(1);
    checks += 2;
    if (q_res[0] !== 48'd11) begin failures++; $display("FAIL post_rst_res got=%0d required=11", q_res[0]); end
    if (q_beats[0] !== 16'd1) begin failures++; $display("FAIL post_rst_beats got=%0d required=1", q_beats[0]); end
  endtask

  task automatic test_abandon();
    clear_q();
    send(ALL1, ALL1, 48'd1000, 1'b1, 1'b0);
    send(ALL1, ALL2, 48'd1, 1'b1, 1'b1);
    wait_results(1);
    checks += 2;
    if (q_res[0] !== 48'd9) begin failures++; $display("FAIL abandon_res got=%0d required=9", q_res[0]); end
    if (q_beats[0] !== 16'd1) begin failures++; $display("FAIL abandon_beats got=%0d required=1", q_beats[0]); end
  endtask

  task automatic test_wrap48();
    clear_q();
    send(ALL1, ALL1, 48'h7FFF_FFFF_FFFF, 1'b1, 1'b1);
    wait_results(1);
    checks++;
`ifdef DOT_MAC_SATURATE_EN
    if (q_res[0] !== 48'h7FFF_FFFF_FFFF) begin failures++; $display("FAIL wrap48_res got=%0h required=7fffffffffff", q_res[0]); end
    checks++;
    if (q_sat[0] !== 1'b1) begin failures++; $display("FAIL wrap48_sat got=%0b required=1", q_sat[0]); end
`else
    if (q_res[0] !== 48'h8000_0000_0003) begin failures++; $display("FAIL wrap48_res got=%0h required=800000000003", q_res[0]); end
`endif
  endtask

  task automatic test_sat33();
    clear_q();
    send({4{16'h7FFF}}, {4{16'h7FFF}}, 48'd0, 1'b1, 1'b0);
    send({4{16'h7FFF}}, {4{16'h7FFF}}, 48'd0, 1'b0, 1'b0);
    send({4{16'h7FFF}}, {4{16'h7FFF}}, 48'd0, 1'b0, 1'b1);
    wait_results(1);
    checks += 2;
    if (q_res[0] !== 48'h2_FFF4_000C) begin failures++; $display("FAIL wide_res got=%0h required=2fff4000c", q_res[0]); end
    if (q_beats[0] !== 16'd3) begin failures++; $display("FAIL wide_beats got=%0d required=3", q_beats[0]); end
    checks++;
`ifdef DOT_MAC_SATURATE_EN
    if (q33_res[0] !== 33'h0_FFFF_FFFF) begin failures++; $display("FAIL sat33_res got=%0h required=ffffffff", q33_res[0]); end
    checks += 2;
    if (q33_sat[0] !== 1'b1) begin failures++; $display("FAIL sat33_flag got=%0b required=1", q33_sat[0]); end
    if (q_sat[0] !== 1'b0) begin failures++; $display("FAIL wide_sat_flag got=%0b required=0", q_sat[0]); end
`else
    if (q33_res[0] !== 33'h0_FFF4_000C) begin failures++; $display("FAIL wrap33_res got=%0h required=fff4000c", q33_res[0]); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_backpressure();
    test_signed();
    test_reset_mid_frame();
    test_abandon();
    test_wrap48();
    test_sat33();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
